// File: rtl/bip_control_unit.sv
// BIP accumulator-processor control unit: PC, opcode decode, branches, HALT,
// global stall and wait-stated data-RAM reads.
module bip_control_unit #(
  parameter int PC_WIDTH      = 11,
  parameter int OPCODE_WIDTH  = 5,
  parameter int OPERAND_WIDTH = 11,
  parameter int RAM_LATENCY   = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] instruction,
  input  logic                                  acc_zero,
  output logic [PC_WIDTH-1:0]                   program_counter,
  output logic [1:0]                            SelA,
  output logic                                  SelB,
  output logic                                  WrAcc,
  output logic                                  Op,
  output logic                                  WrRam,
  output logic                                  RdRam,
  output logic                                  halted,
  output logic                                  busy
);

  localparam int IW = OPCODE_WIDTH + OPERAND_WIDTH;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [3:0] LAT      = 4'(RAM_LATENCY);
  localparam logic       MULTI_OK = (RAM_LATENCY != 0);

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(10);

  logic [1:0]               r_state;
  logic [3:0]               r_cnt;
  logic [PC_WIDTH-1:0]      r_pc;

  logic [OPCODE_WIDTH-1:0]  w_opcode;
  logic [OPERAND_WIDTH-1:0] w_operand;
  logic [PC_WIDTH-1:0]      w_target, w_pc_inc;
  logic [1:0]               w_sela;
  logic                     w_selb, w_wracc, w_op, w_wrram, w_rdram, w_hlt, w_taken;
  logic                     w_active, w_multi, w_last, w_acc_ok;

  assign w_opcode  = instruction[IW-1 -: OPCODE_WIDTH];
  assign w_operand = instruction[OPERAND_WIDTH-1:0];
  assign w_target  = PC_WIDTH'(w_operand);
  assign w_pc_inc  = r_pc + PC_WIDTH'(1);

  always_comb begin
    w_sela  = '0;
    w_selb  = 1'b0;
    w_wracc = 1'b0;
    w_op    = 1'b0;
    w_wrram = 1'b0;
    w_rdram = 1'b0;
    w_hlt   = 1'b0;
    w_taken = 1'b0;
    case (w_opcode)
      OP_HLT:  w_hlt = 1'b1;
      OP_STO:  w_wrram = 1'b1;
      OP_LD:   begin w_wracc = 1'b1; w_rdram = 1'b1; end
      OP_LDI:  begin w_sela = 2'b01; w_wracc = 1'b1; end
      OP_ADD:  begin w_sela = 2'b10; w_wracc = 1'b1; w_rdram = 1'b1; end
      OP_ADDI: begin w_sela = 2'b10; w_selb = 1'b1; w_wracc = 1'b1; end
      OP_SUB:  begin w_sela = 2'b10; w_op = 1'b1; w_wracc = 1'b1; w_rdram = 1'b1; end
      OP_SUBI: begin w_sela = 2'b10; w_selb = 1'b1; w_op = 1'b1; w_wracc = 1'b1; end
      OP_BEQ:  w_taken = acc_zero;
      OP_BNE:  w_taken = ~acc_zero;
      OP_JMP:  w_taken = 1'b1;
      default: ;
    endcase
  end

  // Reads are split across RUN+WAIT; the accumulator is written only on the
  // last enabled WAIT cycle when the data RAM has wait states.
  assign w_active = rst & ((r_state == ST_RUN) | (r_state == ST_WAIT));
  assign w_multi  = MULTI_OK & w_rdram;
  assign w_last   = (r_state == ST_WAIT) & (r_cnt == 4'd1);
  assign w_acc_ok = (r_state == ST_RUN) ? ~w_multi : w_last;

  assign SelA   = w_active ? w_sela : '0;
  assign SelB   = w_active & w_selb;
  assign Op     = w_active & w_op;
  assign RdRam  = w_active & w_rdram;
  assign WrAcc  = w_active & en & w_wracc & w_acc_ok;
  assign WrRam  = w_active & en & w_wrram & (r_state == ST_RUN);
  assign halted = rst & (r_state == ST_HALT);
  assign busy   = rst & (r_state == ST_WAIT);

  assign program_counter = r_pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc    <= '0;
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else if (en) begin
      case (r_state)
        ST_RUN: begin
          if (w_hlt) begin
            r_state <= ST_HALT;
          end else if (w_multi) begin
            r_cnt   <= LAT;
            r_state <= ST_WAIT;
          end else begin
            r_pc <= w_taken ? w_target : w_pc_inc;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_pc    <= w_pc_inc;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_HALT: ;
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: two instances (RAM_LATENCY 0 and 2), vector
// tables for directed sequences plus randomized cycles against a reference model.
module tb_bip_control_unit;
  localparam int PCW = 11;
  localparam int IW  = 16;
  localparam int LAT0 = 0;
  localparam int LAT1 = 2;

  typedef struct {
    logic            r, e, z;
    logic [IW-1:0]   ins;
    logic [PCW-1:0]  pc;
    logic [8:0]      out;  // {SelA, SelB, WrAcc, Op, WrRam, RdRam, halted, busy}
  } vec_t;

  logic clk = 1'b0;
  logic [1:0]          rst = '0, en = '0, az = '0;
  logic [1:0][IW-1:0]  ins = '0;
  logic [1:0][PCW-1:0] pc;
  logic [1:0][1:0]     sela;
  logic [1:0]          selb, wracc, opo, wrram, rdram, hlt, bsy;

  int n_cmp = 0;
  int n_err = 0;
  int m_pc[2];
  int m_done[2];
  bit m_halt[2];
  vec_t tab[$];

  always #5 clk = ~clk;

  bip_control_unit #(.PC_WIDTH(PCW), .OPCODE_WIDTH(5), .OPERAND_WIDTH(11), .RAM_LATENCY(LAT0)) u_l0 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .instruction(ins[0]), .acc_zero(az[0]),
    .program_counter(pc[0]), .SelA(sela[0]), .SelB(selb[0]), .WrAcc(wracc[0]), .Op(opo[0]),
    .WrRam(wrram[0]), .RdRam(rdram[0]), .halted(hlt[0]), .busy(bsy[0]));

  bip_control_unit #(.PC_WIDTH(PCW), .OPCODE_WIDTH(5), .OPERAND_WIDTH(11), .RAM_LATENCY(LAT1)) u_l2 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .instruction(ins[1]), .acc_zero(az[1]),
    .program_counter(pc[1]), .SelA(sela[1]), .SelB(selb[1]), .WrAcc(wracc[1]), .Op(opo[1]),
    .WrRam(wrram[1]), .RdRam(rdram[1]), .halted(hlt[1]), .busy(bsy[1]));

  function automatic logic [IW-1:0] mk(input int op, input int opd);
    logic [31:0] a, b;
    a = op;
    b = opd;
    return {a[4:0], b[10:0]};
  endfunction

  function automatic logic [8:0] outv(input int k);
    return {sela[k], selb[k], wracc[k], opo[k], wrram[k], rdram[k], hlt[k], bsy[k]};
  endfunction

  // Architectural strobe table for a fully enabled, single-cycle instruction.
  function automatic logic [8:0] base(input logic [4:0] op);
    case (op)
      5'd1:    return 9'b00_0_0_0_1_0_0_0;
      5'd2:    return 9'b00_0_1_0_0_1_0_0;
      5'd3:    return 9'b01_0_1_0_0_0_0_0;
      5'd4:    return 9'b10_0_1_0_0_1_0_0;
      5'd5:    return 9'b10_1_1_0_0_0_0_0;
      5'd6:    return 9'b10_0_1_1_0_1_0_0;
      5'd7:    return 9'b10_1_1_1_0_0_0_0;
      default: return 9'b0;
    endcase
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // Model: m_done counts enabled cycles already spent on a RAM read; the
  // read completes on the cycle where that count reaches the latency.
  function automatic logic [8:0] m_exp(input int k, input logic r, e, input logic [IW-1:0] in);
    logic [8:0] d;
    bit rd_multi;
    if (!r) return 9'b0;
    if (m_halt[k]) return 9'b000000010;
    d = base(in[15:11]);
    rd_multi = d[2] && lat(k) > 0;
    d[5] = e && d[5] && (!rd_multi || m_done[k] == lat(k));
    d[3] = e && d[3];
    d[0] = m_done[k] > 0;
    return d;
  endfunction

  task automatic m_step(input int k, input logic r, e, z, input logic [IW-1:0] in);
    int op;
    op = int'(in[15:11]);
    if (!r) begin
      m_pc[k] = 0; m_halt[k] = 0; m_done[k] = 0;
    end else if (m_halt[k] || !e) begin
    end else if (op == 0) begin
      m_halt[k] = 1;
    end else if (base(in[15:11]) [2] && lat(k) > 0) begin
      if (m_done[k] == lat(k)) begin
        m_done[k] = 0;
        m_pc[k] = (m_pc[k] + 1) % 2048;
      end else begin
        m_done[k]++;
      end
    end else if (op == 10 || (op == 8 && z) || (op == 9 && !z)) begin
      m_pc[k] = int'(in[10:0]);
    end else begin
      m_pc[k] = (m_pc[k] + 1) % 2048;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [1:0] r, e, z, input logic [IW-1:0] i0, i1,
                       input bit mdl, input bit use_tab, input int k, input vec_t v);
    rst = r; en = e; az = z; ins[0] = i0; ins[1] = i1;
    @(negedge clk);
    if (mdl) begin
      for (int j = 0; j < 2; j++) begin
        check(j == 0 ? "pc_L0" : "pc_L2", 32'(pc[j]), 32'(m_pc[j]));
        check(j == 0 ? "out_L0" : "out_L2", 32'(outv(j)), 32'(m_exp(j, rst[j], en[j], ins[j])));
      end
    end
    if (use_tab) begin
      check(k == 0 ? "tab_pc_L0" : "tab_pc_L2", 32'(pc[k]), 32'(v.pc));
      check(k == 0 ? "tab_out_L0" : "tab_out_L2", 32'(outv(k)), 32'(v.out));
    end
    @(posedge clk);
    for (int j = 0; j < 2; j++) m_step(j, rst[j], en[j], az[j], ins[j]);
    #1;
  endtask

  task automatic add(input logic r, e, z, input logic [IW-1:0] i, input int p, input logic [8:0] o);
    vec_t v;
    v.r = r; v.e = e; v.z = z; v.ins = i; v.pc = PCW'(p); v.out = o;
    tab.push_back(v);
  endtask

  task automatic run_tab(input int k);
    vec_t v;
    for (int j = 0; j < tab.size(); j++) begin
      v = tab[j];
      if (k == 0) apply({1'b0, v.r}, {1'b0, v.e}, {1'b0, v.z}, v.ins, '0, 1'b1, 1'b1, 0, v);
      else        apply({v.r, 1'b0}, {v.e, 1'b0}, {v.z, 1'b0}, '0, v.ins, 1'b1, 1'b1, 1, v);
    end
    tab.delete();
  endtask

  initial begin
    vec_t nv;
    logic [IW-1:0] ri;
    logic r1, e1, z1;
    int op;
    nv = '{r: 1'b0, e: 1'b0, z: 1'b0, ins: '0, pc: '0, out: '0};
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 0; m_done[i] = 0; m_halt[i] = 0;
    end
    @(posedge clk); #1;
    apply(2'b00, 2'b11, 2'b00, '0, '0, 1'b0, 1'b0, 0, nv);
    apply(2'b00, 2'b11, 2'b00, '0, '0, 1'b0, 1'b0, 0, nv);

    // Latency-0 instance: program flow, branches, wrap, stall, halt.
    add(0, 1, 0, mk(3, 5),      0,     9'h000);
    add(1, 1, 0, mk(3, 5),      0,     9'h0A0);
    add(1, 1, 0, mk(5, 3),      1,     9'h160);
    add(1, 1, 0, mk(1, 7),      2,     9'h008);
    add(1, 1, 0, mk(31, 0),     3,     9'h000);
    add(1, 1, 1, mk(8, 'h20),   4,     9'h000);
    add(1, 1, 0, mk(10, 4),     'h20,  9'h000);
    add(1, 1, 0, mk(8, 'h20),   4,     9'h000);
    add(1, 1, 0, mk(9, 'h100),  5,     9'h000);
    add(1, 1, 0, mk(10, 'h7FF), 'h100, 9'h000);
    add(1, 1, 0, mk(31, 0),     'h7FF, 9'h000);
    add(1, 0, 0, mk(1, 1),      0,     9'h000);
    add(1, 0, 0, mk(2, 9),      0,     9'h004);
    add(1, 1, 0, mk(2, 9),      0,     9'h024);
    add(1, 1, 0, mk(6, 2),      1,     9'h134);
    add(1, 1, 0, mk(7, 2),      2,     9'h170);
    add(1, 1, 0, mk(4, 2),      3,     9'h124);
    add(1, 1, 1, mk(9, 'h10),   4,     9'h000);
    add(1, 1, 0, mk(10, 6),     5,     9'h000);
    add(1, 1, 0, mk(0, 0),      6,     9'h000);
    add(1, 1, 0, mk(3, 1),      6,     9'h002);
    add(1, 0, 0, mk(10, 0),     6,     9'h002);
    add(0, 1, 0, mk(3, 1),      6,     9'h000);
    add(1, 1, 0, mk(3, 1),      0,     9'h0A0);
    run_tab(0);

    // Latency-2 instance: wait states, stall inside WAIT, reset mid-WAIT, halt.
    add(0, 1, 0, mk(31, 0), 0, 9'h000);
    add(1, 1, 0, mk(10, 3), 0, 9'h000);
    add(1, 1, 0, mk(2, 9),  3, 9'h004);
    add(1, 1, 0, mk(2, 9),  3, 9'h005);
    add(1, 1, 0, mk(2, 9),  3, 9'h025);
    add(1, 1, 0, mk(2, 9),  4, 9'h004);
    add(1, 1, 0, mk(2, 9),  4, 9'h005);
    add(1, 0, 0, mk(2, 9),  4, 9'h005);
    add(1, 0, 0, mk(2, 9),  4, 9'h005);
    add(1, 0, 0, mk(2, 9),  4, 9'h005);
    add(1, 1, 0, mk(2, 9),  4, 9'h025);
    add(1, 1, 0, mk(2, 9),  5, 9'h004);
    add(1, 1, 0, mk(2, 9),  5, 9'h005);
    add(0, 1, 0, mk(2, 9),  5, 9'h000);
    add(1, 1, 0, mk(31, 0), 0, 9'h000);
    add(1, 1, 0, mk(10, 6), 1, 9'h000);
    add(1, 1, 0, mk(0, 0),  6, 9'h000);
    for (int i = 0; i < 12; i++)
      add(1, 1'($urandom % 2), 1'($urandom % 2), 16'($urandom), 6, 9'h002);
    add(0, 1, 0, mk(3, 1),  6, 9'h000);
    add(1, 1, 0, mk(31, 0), 0, 9'h000);
    run_tab(1);

    // Randomized run on both instances; instruction held while a read is in flight.
    apply(2'b00, 2'b11, 2'b00, '0, '0, 1'b1, 1'b0, 0, nv);
    ri = mk(31, 0);
    for (int c = 0; c < 3000; c++) begin
      r1 = ($urandom % 64) != 0;
      e1 = ($urandom % 5) != 0;
      z1 = 1'($urandom % 2);
      if (m_done[1] == 0) begin
        op = (($urandom % 40) == 0) ? 0 : int'($urandom_range(1, 12));
        if (op > 10) op = 31;
        ri = mk(op, int'($urandom % 2048));
      end
      apply({r1, r1}, {e1, e1}, {z1, z1}, ri, ri, 1'b1, 1'b0, 0, nv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
